// File: rtl/adap_pred_rec_sig_mc.sv
// rtl/adap_pred_rec_sig_mc.sv - time-multiplexed ADDB/ADDC reconstructed signal with per-channel PK history
module adap_pred_rec_sig_mc #(
  parameter int NCH  = 4,
  parameter int CH_W = 2,
  parameter int DQ_W = 15,
  parameter int SE_W = 15,
  parameter int SR_W = SE_W + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            scan_in0,
  input  logic            scan_en,
  output logic            scan_out0,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] in_ch,
  input  logic            in_init,
  input  logic [DQ_W-1:0] dq,
  input  logic [SE_W-1:0] se,
  input  logic [SE_W-1:0] sez,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [SR_W-1:0] sr,
  output logic            pk0,
  output logic            pk1,
  output logic            pk2,
  output logic            sigpk
);

  // Scan chain is stitched in by DFT; the RTL only ties off the output.
  logic unused_scan;
  assign unused_scan = scan_in0 ^ scan_en;
  assign scan_out0   = 1'b0;

  logic            a_valid;
  logic            a_init;
  logic [CH_W-1:0] a_ch;
  logic [DQ_W-1:0] a_dq;
  logic [SE_W-1:0] a_se;
  logic [SE_W-1:0] a_sez;
  logic            b_valid;
  logic            b_adv;
  logic            ab_xfer;
  logic [NCH-1:0]  hist_pk1;
  logic [NCH-1:0]  hist_pk2;
  logic [SR_W-1:0] mag_ext;
  logic [SR_W-1:0] dqi;
  logic [SR_W-1:0] sei;
  logic [SR_W-1:0] sezi;
  logic [SR_W-1:0] sr_c;
  logic [SR_W-1:0] dqsez;
  logic            ch_ok;
  logic            rd_pk1;
  logic            rd_pk2;

  assign b_adv     = !b_valid || out_ready;
  assign in_ready  = !a_valid || b_adv;
  assign ab_xfer   = a_valid && b_adv;
  assign out_valid = b_valid;

  // Stage-A arithmetic and history read; init or an out-of-range channel reads zero history.
  always_comb begin
    mag_ext = SR_W'(a_dq[DQ_W-2:0]);
    dqi     = a_dq[DQ_W-1] ? (~mag_ext + 1'b1) : mag_ext;
    sei     = {{(SR_W-SE_W){a_se[SE_W-1]}}, a_se};
    sezi    = {{(SR_W-SE_W){a_sez[SE_W-1]}}, a_sez};
    sr_c    = dqi + sei;
    dqsez   = dqi + sezi;
    ch_ok   = (int'(a_ch) < NCH);
    rd_pk1  = ch_ok && !a_init && hist_pk1[a_ch];
    rd_pk2  = ch_ok && !a_init && hist_pk2[a_ch];
  end

  // Stage A: capture the sample whenever the slot is free or draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_init  <= 1'b0;
      a_ch    <= '0;
      a_dq    <= '0;
      a_se    <= '0;
      a_sez   <= '0;
    end else if (in_ready) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_init <= in_init;
        a_ch   <= in_ch;
        a_dq   <= dq;
        a_se   <= se;
        a_sez  <= sez;
      end
    end
  end

  // Stage B: register results; held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_valid <= 1'b0;
      out_ch  <= '0;
      sr      <= '0;
      pk0     <= 1'b0;
      pk1     <= 1'b0;
      pk2     <= 1'b0;
      sigpk   <= 1'b0;
    end else if (b_adv) begin
      b_valid <= a_valid;
      if (a_valid) begin
        out_ch <= a_ch;
        sr     <= sr_c;
        pk0    <= dqsez[SR_W-1];
        pk1    <= rd_pk1;
        pk2    <= rd_pk2;
        sigpk  <= (dqsez == '0);
      end
    end
  end

  // History shifts at the single A->B update point, so same-channel back-to-back needs no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_pk1 <= '0;
      hist_pk2 <= '0;
    end else if (ab_xfer && ch_ok) begin
      hist_pk1[a_ch] <= dqsez[SR_W-1];
      hist_pk2[a_ch] <= rd_pk1;
    end
  end

endmodule
